seq_div: RTL and testbench

Sequential unsigned restoring divider, companion to the combinational N-bit multiplier in the MulDiv task. It computes Q = A / B and R = A % B, producing one quotient bit per clock. Callers use a start/busy/done handshake. The bench checks it against the multiplier identity A == Q*B + R.

---
 rtl/seq_div.sv | 106 ++++++++++
 tb/tb_seq_div.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: Q = A / B, R = A % B, one quotient
// bit per clock, with a start/busy/done handshake and a divide-by-zero flag.
module seq_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [1:0]   state_dbg
);

  // Handshake: start is accepted on a rising edge only in IDLE or DONE, and
  // A/B are sampled on that same edge. busy stays high for the N RUN cycles.
  // done pulses for exactly one cycle when Q/R/div_by_zero become valid.
  // Those results then hold until the next accepted division completes.
  // A start seen during RUN is dropped with no side effects.

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [N-1:0]  rem;

  logic [N:0]    rem_sh;
  logic [N-1:0]  rem_sub;
  logic [N-1:0]  rem_nxt;
  logic          q_bit;

  // When the subtraction is taken the true difference is below B, so the
  // low N bits of the shifted remainder minus B are exact.
  always_comb begin
    rem_sh  = {rem, dvd[N-1]};
    q_bit   = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[N-1:0] - dvs;
    rem_nxt = q_bit ? rem_sub : rem_sh[N-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd <= A;
            dvs <= B;
            rem <= '0;
            cnt <= CW'(N);
            if (B == '0) begin
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= {dvd[N-2:0], q_bit};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q     <= {dvd[N-2:0], q_bit};
            R     <= rem_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed divisions, handshake corner cases, mid-run reset
// and a sweep of every nonzero-divisor pair checked against A == Q*B + R.
module tb_seq_div;

  localparam int N = 4;
  localparam int EW = 4 * N + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Expected entries: {dbz, a, b, q, r}
  logic [EW-1:0] exp_q[$];

  seq_div #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input int a, input int b, input int q, input int r, input bit dbz);
    exp_q.push_back({dbz, N'(a), N'(b), N'(q), N'(r)});
  endtask

  // driver: called at a negedge, leaves at the following negedge
  task automatic issue(input int a, input int b);
    A = N'(a);
    B = N'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wait for done (bounded), checking latency and busy cycles seen
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int lat = 0;
    int bcnt = 0;
    while (!done && lat < 50) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bcnt, exp_busy);
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [EW-1:0] e;
        logic [N-1:0] ea, eb, eq, er;
        logic ed;
        e = exp_q.pop_front();
        {ed, ea, eb, eq, er} = e;
        check("q", int'(Q), int'(eq));
        check("r", int'(R), int'(er));
        check("div_by_zero", int'(div_by_zero), int'(ed));
        if (eb != '0) begin
          check("identity_q_b_plus_r", int'(Q) * int'(eb) + int'(R), int'(ea));
          check("r_lt_b", int'(R < eb), 1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check("reset_q", int'(Q), 0);
    check("reset_r", int'(R), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    check("reset_state", int'(state_dbg), 0);
    reset = 1'b0;
    @(negedge clk);

    // directed vectors
    push_exp(0, 1, 0, 0, 0);   issue(0, 1);   wait_done("a0_b1", N, N);
    push_exp(15, 1, 15, 0, 0); issue(15, 1);  wait_done("a15_b1", N, N);
    push_exp(15, 15, 1, 0, 0); issue(15, 15); wait_done("a15_b15", N, N);
    push_exp(15, 4, 3, 3, 0);  issue(15, 4);  wait_done("a15_b4", N, N);

    // divide by zero, then the flag clears on the next result
    push_exp(9, 0, 15, 9, 1);  issue(9, 0);   wait_done("a9_b0", 0, 0);
    push_exp(9, 2, 4, 1, 0);   issue(9, 2);   wait_done("a9_b2", N, N);

    // start during RUN is ignored
    push_exp(13, 3, 4, 1, 0);
    issue(13, 3);
    issue(2, 1);
    @(negedge clk);
    @(negedge clk);
    // hold start through the DONE cycle: back-to-back run with no idle gap
    push_exp(7, 2, 3, 1, 0);
    A = 4'd7;
    B = 4'd2;
    start = 1'b1;
    @(negedge clk);
    check("b2b_done_seen", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_no_gap", int'(busy), 1);
    wait_done("a7_b2_b2b", N, N);

    // reset mid-operation
    issue(14, 5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_q", int'(Q), 0);
    check("midrst_r", int'(R), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_state", int'(state_dbg), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    push_exp(14, 5, 2, 4, 0); issue(14, 5); wait_done("a14_b5", N, N);

    // sweep all nonzero-divisor pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        push_exp(a, b, a / b, a % b, 0);
        issue(a, b);
        wait_done("sweep", N, N);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
